// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pool reader of the conv2d layer-1 feature map.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } pool_state_t;

    localparam int POOL_CH        = 32;
    localparam int POOL_IN_DIM    = 26;
    localparam int FMAP_CH_STRIDE = POOL_IN_DIM * POOL_IN_DIM;

    // Bit k of each mask gives the row/column offset of window sample k.
    localparam logic [3:0] WIN_ROW_OFS = 4'b1100;
    localparam logic [3:0] WIN_COL_OFS = 4'b1010;

    function automatic logic [31:0] win_offset(input logic [1:0] k, input int in_dim);
        logic [31:0] ofs;
        ofs = WIN_ROW_OFS[k] ? 32'(in_dim) : 32'd0;
        ofs = ofs + (WIN_COL_OFS[k] ? 32'd1 : 32'd0);
        return ofs;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Channel/row/column/window-sample counters and byte address generation for the pooling reader.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int          CH        = POOL_CH,
    parameter int          IN_DIM    = POOL_IN_DIM,
    parameter int          OUT_DIM   = IN_DIM / 2,
    parameter logic [31:0] FMAP_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        step_k,
    input  logic        step_out,
    output logic [31:0] addr,
    output logic [1:0]  k,
    output logic        is_last
);

    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int POS_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CH_W-1:0]  CH_MAX    = CH_W'(CH - 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(OUT_DIM - 1);
    localparam logic [31:0]      CH_STRIDE = 32'(IN_DIM * IN_DIM);

    logic [CH_W-1:0]  ch_reg, ch_next;
    logic [POS_W-1:0] pr_reg, pr_next;
    logic [POS_W-1:0] pc_reg, pc_next;
    logic [1:0]       k_reg, k_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ch_reg <= '0;
            pr_reg <= '0;
            pc_reg <= '0;
            k_reg  <= '0;
        end else begin
            ch_reg <= ch_next;
            pr_reg <= pr_next;
            pc_reg <= pc_next;
            k_reg  <= k_next;
        end
    end

    // pc is innermost, then pr, then ch; everything wraps to 0 after the last window.
    always_comb begin
        ch_next = ch_reg;
        pr_next = pr_reg;
        pc_next = pc_reg;
        k_next  = k_reg;
        if (clear) begin
            ch_next = '0;
            pr_next = '0;
            pc_next = '0;
            k_next  = '0;
        end else if (step_out) begin
            k_next = '0;
            if (pc_reg == POS_MAX) begin
                pc_next = '0;
                if (pr_reg == POS_MAX) begin
                    pr_next = '0;
                    ch_next = (ch_reg == CH_MAX) ? '0 : ch_reg + CH_W'(1);
                end else begin
                    pr_next = pr_reg + POS_W'(1);
                end
            end else begin
                pc_next = pc_reg + POS_W'(1);
            end
        end else if (step_k) begin
            k_next = k_reg + 2'd1;
        end
    end

    logic [31:0] pix00;
    logic [31:0] win_addr [4];

    assign pix00 = FMAP_BASE
                 + 32'(ch_reg) * CH_STRIDE
                 + 32'({pr_reg, 1'b0}) * 32'(IN_DIM)
                 + 32'({pc_reg, 1'b0});

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            assign win_addr[gi] = pix00 + win_offset(2'(gi), IN_DIM);
        end
    endgenerate

    assign addr    = win_addr[k_reg];
    assign k       = k_reg;
    assign is_last = (ch_reg == CH_MAX) && (pr_reg == POS_MAX) && (pc_reg == POS_MAX);

endmodule

// File: rtl/maxpool2x2_fmap_reader.sv
// Reads the conv2d layer-1 feature map byte by byte, 2x2/stride-2 signed max-pools it and
// streams the pooled bytes (channel, row, column order) on a valid/ready interface.
module maxpool2x2_fmap_reader
    import pool_pkg::*;
#(
    parameter int          CH        = POOL_CH,
    parameter int          IN_DIM    = POOL_IN_DIM,
    parameter int          OUT_DIM   = IN_DIM / 2,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] FMAP_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [31:0] fmap_addr,
    input  logic [7:0]  fmap_data,
    output logic        fmap_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    pool_state_t     state_reg, state_next;
    logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0]      max_reg, max_next;

    logic        gen_clear;
    logic        gen_step_k;
    logic        gen_step_out;
    logic [31:0] gen_addr;
    logic [1:0]  gen_k;
    logic        gen_last;

    pool_addr_gen #(
        .CH        (CH),
        .IN_DIM    (IN_DIM),
        .OUT_DIM   (OUT_DIM),
        .FMAP_BASE (FMAP_BASE)
    ) u_addr_gen (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (gen_clear),
        .step_k   (gen_step_k),
        .step_out (gen_step_out),
        .addr     (gen_addr),
        .k        (gen_k),
        .is_last  (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            max_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            max_reg      <= max_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        max_next      = max_reg;
        gen_clear     = 1'b0;
        gen_step_k    = 1'b0;
        gen_step_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    gen_clear  = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                wait_cnt_next = WC_W'(RD_LAT - 1);
                state_next    = WAIT;
            end
            WAIT: begin
                // ADDR plus the WAIT cycles give RD_LAT cycles of stable address before CAPTURE.
                if (wait_cnt_reg <= WC_W'(1)) begin
                    wait_cnt_next = '0;
                    state_next    = CAPTURE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WC_W'(1);
                end
            end
            CAPTURE: begin
                // Strict compare so ties keep the earlier sample.
                if (gen_k == 2'd0 || $signed(fmap_data) > $signed(max_reg)) begin
                    max_next = fmap_data;
                end
                if (gen_k == 2'd3) begin
                    state_next = EMIT;
                end else begin
                    gen_step_k = 1'b1;
                    state_next = ADDR;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    gen_step_out = 1'b1;
                    state_next   = gen_last ? DONE : ADDR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only, so none depends combinationally on out_ready.
    assign busy      = (state_reg == ADDR) || (state_reg == WAIT) ||
                       (state_reg == CAPTURE) || (state_reg == EMIT);
    assign fmap_en   = busy;
    assign fmap_addr = busy ? gen_addr : 32'd0;
    assign out_valid = (state_reg == EMIT);
    assign out_data  = out_valid ? max_reg : 8'd0;
    assign out_last  = out_valid & gen_last;
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_maxpool2x2_fmap_reader.sv
// Randomized bench for the 2x2 max-pool reader: BRAM model with read latency, reference pooling
// model over the stored feature map, handshake/stall scoreboard and address-sequence checks.
module tb_maxpool2x2_fmap_reader;

    localparam int          CH     = 32;
    localparam int          IN_DIM = 26;
    localparam int          OD     = IN_DIM / 2;
    localparam int          RD_LAT = 2;
    localparam int          TOTAL  = CH * OD * OD;
    localparam int          MEMSZ  = CH * IN_DIM * IN_DIM;
    localparam logic [31:0] BASE   = 32'd0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  fmap_data = 8'd0;
    logic [31:0] fmap_addr;
    logic        fmap_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    maxpool2x2_fmap_reader #(
        .CH        (CH),
        .IN_DIM    (IN_DIM),
        .OUT_DIM   (OD),
        .RD_LAT    (RD_LAT),
        .FMAP_BASE (BASE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .fmap_addr (fmap_addr),
        .fmap_data (fmap_data),
        .fmap_en   (fmap_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Two-stage read pipeline: data for an address is visible RD_LAT edges later.
    logic [7:0] mem [MEMSZ];
    logic [7:0] rd1 = 8'd0;
    always @(posedge clk) begin
        if (int'(fmap_addr - BASE) < MEMSZ) rd1 <= mem[int'(fmap_addr - BASE)];
        else                                rd1 <= 8'h00;
        fmap_data <= rd1;
    end

    int total = 0;
    int bad = 0;
    int n_out, n_done, ready_mode;
    bit mon_on = 1'b0;
    bit stall_prev, prev_en;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic [31:0] prev_addr;
    int run_len, min_run;
    int         addr_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic int ref_addr(input int o, input int k);
        int ch, pr, pc;
        ch = o / (OD * OD);
        pr = (o / OD) % OD;
        pc = o % OD;
        return int'(BASE) + ch * IN_DIM * IN_DIM + (2 * pr + k / 2) * IN_DIM + (2 * pc + k % 2);
    endfunction

    function automatic logic [7:0] ref_pool(input int o);
        int m, v;
        m = -1000;
        for (int k = 0; k < 4; k++) begin
            v = sx(mem[ref_addr(o, k) - int'(BASE)]);
            if (v > m) m = v;
        end
        return 8'(m);
    endfunction

    task automatic fill_mem(input bit patterns);
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        if (patterns) begin
            for (int i = 0; i < IN_DIM * IN_DIM; i++) mem[i] = 8'(i % 128);
            mem[676 + 0]  = 8'h80; mem[676 + 1]  = 8'hFB; mem[676 + 26] = 8'hFF; mem[676 + 27] = 8'h9C;
            mem[676 + 2]  = 8'h80; mem[676 + 3]  = 8'h80; mem[676 + 28] = 8'h80; mem[676 + 29] = 8'h80;
            mem[676 + 4]  = 8'h7F; mem[676 + 5]  = 8'h7F; mem[676 + 30] = 8'h00; mem[676 + 31] = 8'hFF;
        end
    endtask

    task automatic mon_reset();
        stall_prev = 1'b0;
        prev_en    = 1'b0;
        run_len    = 0;
        min_run    = 1000000;
        n_out      = 0;
        n_done     = 0;
        addr_q.delete();
        got_q.delete();
    endtask

    // One clock: observe outputs on the falling edge, then choose out_ready for the next rising edge.
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 30);
            default: out_ready = 1'b0;
        endcase
        if (mon_on) begin
            if (done) n_done++;
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hold_data));
                check("stall_last", 32'(out_last), 32'(hold_last));
            end
            if (fmap_en) begin
                if (!prev_en || fmap_addr != prev_addr) begin
                    if (prev_en && run_len < min_run) min_run = run_len;
                    addr_q.push_back(int'(fmap_addr));
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else if (prev_en && run_len < min_run) begin
                min_run = run_len;
            end
            prev_en   = fmap_en;
            prev_addr = fmap_addr;
            if (out_valid && out_ready) begin
                exp = ref_pool(n_out);
                check("data", 32'(out_data), 32'(exp));
                check("last", 32'(out_last), 32'(n_out == TOTAL - 1));
                got_q.push_back(out_data);
                $display("xfer %0d ch=%0d pr=%0d pc=%0d data=%02h exp=%02h last=%0b",
                         n_out, n_out / (OD * OD), (n_out / OD) % OD, n_out % OD,
                         out_data, exp, out_last);
                n_out++;
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_last  = out_last;
        end
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (n_out < target && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(n_out), 32'(target));
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_addr"},  fmap_addr, 32'd0);
        check({pfx, "_en"},    32'(fmap_en), 32'd0);
        check({pfx, "_data"},  32'(out_data), 32'd0);
        check({pfx, "_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_last"},  32'(out_last), 32'd0);
        check({pfx, "_busy"},  32'(busy), 32'd0);
        check({pfx, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        int c;
        ready_mode = 0;
        mon_reset();
        fill_mem(1'b1);

        resetn = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        resetn = 1'b1;
        tick();

        // Full pass, ramp/pattern memory, downstream always ready.
        mon_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        run_until(TOTAL, 80000, "passA_count");
        c = 0;
        while (!done && c < 10) begin
            tick();
            c++;
        end
        check("done_seen", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_with_done_ignored", 32'(busy), 32'd0);
        repeat (3) tick();
        check("done_pulses", 32'(n_done), 32'd1);
        check("addr_hold_ge_rdlat", 32'(min_run >= RD_LAT), 32'd1);
        check("addr_count", 32'(addr_q.size()), 32'(TOTAL * 4));
        if (addr_q.size() == TOTAL * 4) begin
            for (int o = 0; o < TOTAL; o++)
                for (int k = 0; k < 4; k++)
                    check("addr_seq", 32'(addr_q[o * 4 + k]), 32'(ref_addr(o, k)));
            check("addr_ch1_k0", 32'(addr_q[169 * 4]), 32'd676);
            check("addr_final", 32'(addr_q[TOTAL * 4 - 1]), 32'd21631);
        end
        if (got_q.size() >= 172) begin
            check("ramp_byte0", 32'(got_q[0]), 32'd27);
            check("ramp_byte1", 32'(got_q[1]), 32'd29);
            check("win_mixed_neg", 32'(got_q[169]), 32'hFF);
            check("win_all_min", 32'(got_q[170]), 32'h80);
            check("win_tie_max", 32'(got_q[171]), 32'h7F);
        end

        // Random memory, random back-pressure, ignored start while busy, reset mid-EMIT.
        mon_on = 1'b0;
        fill_mem(1'b0);
        mon_reset();
        ready_mode = 1;
        mon_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(50, 3000, "passB_count50");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_while_busy", 32'(busy), 32'd1);
        run_until(100, 3000, "passB_count100");
        ready_mode = 2;
        c = 0;
        while (!out_valid && c < 100) begin
            tick();
            c++;
        end
        check("emit_before_reset", 32'(out_valid), 32'd1);
        mon_on = 1'b0;
        resetn = 1'b0;
        tick();
        check_outputs_zero("midreset");
        resetn = 1'b1;
        tick();
        check("idle_after_reset", 32'(busy), 32'd0);

        // Fresh pass after reset must restart from the first window.
        mon_reset();
        ready_mode = 1;
        mon_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_addr", fmap_addr, BASE);
        check("restart_en", 32'(fmap_en), 32'd1);
        run_until(20, 2000, "passC_count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_fmap_reader.md
Name: maxpool2x2_fmap_reader

Overview:
- Consumer of the conv2d layer-1 output BRAM. It reads the 26x26x32 signed int8 feature map through that engine's byte read port (fmap_addr / fmap_data).
- It computes 2x2 stride-2 signed max-pooling and streams 13x13x32 pooled bytes downstream on a valid/ready interface.
- It sits between the conv2d engine and the next layer (or a debug/UART dump).

Parameters:
- CH, 32, number of channels (filters) in the feature map
- IN_DIM, 26, input feature map width/height; must be even
- OUT_DIM, IN_DIM/2, pooled width/height (derived)
- RD_LAT, 2, cycles fmap_addr is held stable before fmap_data is sampled
- FMAP_BASE, 0, byte base address of channel 0 in the conv output BRAM

Ports:
- clk, input, 1, clock
- resetn, input, 1, synchronous active-low reset
- start, input, 1, begin pooling pass; tie to conv2d done pulse
- fmap_addr, output, 32, byte address into conv output BRAM read port
- fmap_data, input, 8, signed byte returned for fmap_addr
- fmap_en, output, 1, read enable to BRAM port B
- out_data, output, 8, pooled signed byte
- out_valid, output, 1, out_data valid
- out_ready, input, 1, downstream accepts out_data
- out_last, output, 1, marks final pooled byte (ch CH-1, row OUT_DIM-1, col OUT_DIM-1)
- busy, output, 1, high from accepted start until done
- done, output, 1, one-cycle pulse after last handshake

Behaviour:
- Reset value of every output is 0: fmap_addr, fmap_en, out_data, out_valid, out_last, busy and done are all 0. Reset mid-operation aborts the pass and returns the FSM to IDLE with all counters cleared. No partial output is completed after reset.
- Address map (matches conv output layout, channel-major, row-major, byte 0 at word bits [31:24]): addr = FMAP_BASE + ch*IN_DIM*IN_DIM + r*IN_DIM + c.
- Window sample order for output (ch, pr, pc), with k = 0..3:
  - k0 = (2pr, 2pc)
  - k1 = (2pr, 2pc+1)
  - k2 = (2pr+1, 2pc)
  - k3 = (2pr+1, 2pc+1)
- Output order: ch outer, pr, then pc inner, giving CH*OUT_DIM*OUT_DIM = 5408 bytes by default.
- FSM states: IDLE, ADDR, WAIT, CAPTURE, EMIT, DONE.
  - IDLE: busy=0. On start=1, clear ch/pr/pc/k and go to ADDR with busy=1.
  - ADDR: drive fmap_addr for the current (ch, pr, pc, k), set fmap_en=1, load wait counter = RD_LAT-1, go to WAIT.
  - WAIT: hold fmap_addr stable. Decrement the counter; at 0 go to CAPTURE.
  - CAPTURE: sample fmap_data.
    - k=0: max_reg <= fmap_data.
    - Otherwise: max_reg <= signed greater of max_reg and fmap_data.
    - If k<3, k++ and go to ADDR. If k=3, go to EMIT with out_data = final max and out_valid=1.
  - EMIT: hold out_data, out_valid and out_last stable while out_ready=0. On the cycle where out_valid && out_ready:
    - Drop out_valid and advance pc, then pr, then ch.
    - If the byte was last, go to DONE; else go to ADDR.
  - DONE: done=1 for one cycle, busy=0, fmap_en=0, then go to IDLE.
- Latency: each output byte takes 4*(RD_LAT+1) cycles plus 1 EMIT cycle minimum. With RD_LAT=2 this is 13 cycles per byte at full throughput.
- Arithmetic: comparison is 8-bit two's complement (-128 < 127). Ties keep max_reg. No saturation is needed.
- start while busy is ignored. start in the same cycle as done is ignored; it is accepted from IDLE only.
- out_ready high before out_valid has no effect. out_valid never depends combinationally on out_ready.
- fmap_en stays 1 throughout busy so that the BRAM port stays enabled.
- Counters: ch and pr/pc are sized from CH and OUT_DIM ($clog2). Address arithmetic is done at 32 bits.

Decomposition:
- Shared package pool_pkg:
  - pool_state_t enum (IDLE, ADDR, WAIT, CAPTURE, EMIT, DONE)
  - localparams for the 2x2 window offsets
  - localparam FMAP_CH_STRIDE = IN_DIM*IN_DIM (676)
- One sub-module, pool_addr_gen, holds the ch/pr/pc/k counters.
  - Inputs: clear, step_k and step_out strobes.
  - Outputs: the byte address and is_last.
  - The top level holds the FSM, max_reg and the output handshake.

Test Plan:
- Channel 0 = ramp (byte = (r*26+c) mod 128), out_ready=1 -> first pooled byte = 27, second = 29. Total 5408 handshakes, out_last only on the 5408th byte, done pulses once.
- Window with bytes {-128, -5, -1, -100} at (0,0),(0,1),(1,0),(1,1) -> out_data = 8'hFF (-1).
- Window all -128 -> 8'h80. Window {127, 127, 0, -1} -> 8'h7F (tie keeps first).
- out_ready toggled randomly at 30% high -> out_data/out_valid are stable while stalled, and no byte is dropped or duplicated (scoreboard vs reference model).
- Address check:
  - ch=1, pr=0, pc=0, k=0 -> fmap_addr = 676.
  - ch=31, pr=12, pc=12, k=3 -> fmap_addr = 31*676 + 25*26 + 25 = 21631.
  - fmap_addr is stable for RD_LAT cycles before each sample.
- resetn=0 during EMIT of byte 100 -> all outputs 0 next cycle. A fresh start then restarts from addr FMAP_BASE with first output for (0,0,0). A start pulse while busy produces no restart.
